// File: rtl/mux4a2_cond_l1.sv
// rtl/mux4a2_cond_l1.sv - L1 4-to-2 serializing mux with per-lane input FIFOs
//
// Four byte lanes are buffered in small FIFOs and interleaved onto two
// registered output lanes: output 0 serves lanes 0/1, output 1 serves 2/3.
// Each output prefers one of its two lanes and flips the preference to the
// other lane after every grant, so two busy lanes alternate strictly while a
// single busy lane drains at one byte per cycle.
//
// Ports:
//   clk_2f               single clock, rising edge
//   reset                synchronous, active-high
//   valid_in0..3         lane N offers data_inN this cycle
//   data_in0..3          lane N input byte
//   ready_in0..3         lane N FIFO has room (from the count only)
//   validout0..1         dataoutK carries a fresh byte (registered)
//   dataout0..1          output byte (registered, holds when idle)
module mux4a2_cond_l1 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic              ready_in0,
  output logic              ready_in1,
  output logic              ready_in2,
  output logic              ready_in3,
  output logic              validout0,
  output logic              validout1,
  output logic [DATA_W-1:0] dataout0,
  output logic [DATA_W-1:0] dataout1
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [3:0]             valid_in_w;
  logic [3:0][DATA_W-1:0] data_in_w;
  logic [3:0]             ready_w;
  logic [3:0]             push;
  logic [3:0]             pop;

  logic [3:0][FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [3:0][PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [3:0][PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [3:0][CNT_W-1:0]                  cnt_q, cnt_d;

  logic [1:0]             sel_q, sel_d;
  logic [1:0]             validout_q, validout_d;
  logic [1:0][DATA_W-1:0] dataout_q, dataout_d;

  assign valid_in_w = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign data_in_w  = {data_in3, data_in2, data_in1, data_in0};

  // Ready is deliberately blind to a same-cycle pop so it depends on the
  // registered count alone and never forms a path through the arbiter.
  always_comb begin
    ready_w = '0;
    push    = '0;
    for (int n = 0; n < 4; n++) begin
      ready_w[n[1:0]] = !reset && (cnt_q[n[1:0]] < FULL_CNT);
      push[n[1:0]]    = valid_in_w[n[1:0]] && ready_w[n[1:0]];
    end
  end

  // Per-output arbiter: preferred lane if non-empty, else the other lane.
  always_comb begin
    logic [1:0] la;
    logic [1:0] lb;
    logic       ne_a;
    logic       ne_b;
    logic       take_a;
    logic       take_b;
    pop        = '0;
    sel_d      = sel_q;
    validout_d = '0;
    dataout_d  = dataout_q;
    la         = '0;
    lb         = '0;
    ne_a       = 1'b0;
    ne_b       = 1'b0;
    take_a     = 1'b0;
    take_b     = 1'b0;
    for (int k = 0; k < 2; k++) begin
      la     = {k[0], 1'b0};
      lb     = {k[0], 1'b1};
      ne_a   = cnt_q[la] != '0;
      ne_b   = cnt_q[lb] != '0;
      take_a = ne_a && (!sel_q[k[0]] || !ne_b);
      take_b = ne_b && ( sel_q[k[0]] || !ne_a);
      if (take_a) begin
        pop[la]             = 1'b1;
        dataout_d[k[0]]     = mem_q[la][rd_ptr_q[la]];
        validout_d[k[0]]    = 1'b1;
        sel_d[k[0]]         = 1'b1;
      end else if (take_b) begin
        pop[lb]             = 1'b1;
        dataout_d[k[0]]     = mem_q[lb][rd_ptr_q[lb]];
        validout_d[k[0]]    = 1'b1;
        sel_d[k[0]]         = 1'b0;
      end
    end
  end

  // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int n = 0; n < 4; n++) begin
      if (push[n[1:0]]) begin
        mem_d[n[1:0]][wr_ptr_q[n[1:0]]] = data_in_w[n[1:0]];
        wr_ptr_d[n[1:0]] = wr_ptr_q[n[1:0]] + PTR_W'(1);
      end
      if (pop[n[1:0]]) begin
        rd_ptr_d[n[1:0]] = rd_ptr_q[n[1:0]] + PTR_W'(1);
      end
      case ({push[n[1:0]], pop[n[1:0]]})
        2'b10:   cnt_d[n[1:0]] = cnt_q[n[1:0]] + CNT_W'(1);
        2'b01:   cnt_d[n[1:0]] = cnt_q[n[1:0]] - CNT_W'(1);
        default: cnt_d[n[1:0]] = cnt_q[n[1:0]];
      endcase
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      validout_q <= '0;
      dataout_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      validout_q <= validout_d;
      dataout_q  <= dataout_d;
    end
  end

  // Storage needs no reset: a zero count makes stale entries unreachable.
  always_ff @(posedge clk_2f) begin
    mem_q <= mem_d;
  end

  assign ready_in0 = ready_w[0];
  assign ready_in1 = ready_w[1];
  assign ready_in2 = ready_w[2];
  assign ready_in3 = ready_w[3];
  assign validout0 = validout_q[0];
  assign validout1 = validout_q[1];
  assign dataout0  = dataout_q[0];
  assign dataout1  = dataout_q[1];

endmodule

// File: tb/tb_mux4a2_cond_l1.sv
// tb/tb_mux4a2_cond_l1.sv - self-checking bench for mux4a2_cond_l1
module tb_mux4a2_cond_l1;

  localparam int DEPTH = 2;

  logic       clk_2f = 1'b0;
  logic       rst;
  logic       vi  [4];
  logic [7:0] di  [4];
  logic       rdy [4];
  logic       vo0, vo1;
  logic [7:0] do0, do1;

  always #5 clk_2f = ~clk_2f;

  mux4a2_cond_l1 #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_2f    (clk_2f),
    .reset     (rst),
    .valid_in0 (vi[0]),
    .valid_in1 (vi[1]),
    .valid_in2 (vi[2]),
    .valid_in3 (vi[3]),
    .data_in0  (di[0]),
    .data_in1  (di[1]),
    .data_in2  (di[2]),
    .data_in3  (di[3]),
    .ready_in0 (rdy[0]),
    .ready_in1 (rdy[1]),
    .ready_in2 (rdy[2]),
    .ready_in3 (rdy[3]),
    .validout0 (vo0),
    .validout1 (vo1),
    .dataout0  (do0),
    .dataout1  (do1)
  );

  // Reference model: one byte queue per lane plus each output's preferred lane.
  logic [7:0] mq [4][$];
  logic       pref   [2];
  logic       ev     [2];
  logic [7:0] ed     [2];
  logic       pushed [4];
  int         low_cnt[4];
  int         cyc;
  logic [7:0] log0[$], log1[$];
  int         lc0[$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic er[4];
    int   g[2];
    #1;
    for (int n = 0; n < 4; n++) begin
      er[n] = !rst && (mq[n].size() < DEPTH);
      chk($sformatf("ready_in%0d", n), {31'b0, rdy[n]}, {31'b0, er[n]});
      pushed[n] = vi[n] && er[n];
      if (!rst && !er[n]) low_cnt[n]++;
    end
    for (int k = 0; k < 2; k++) begin
      int p, o;
      p = pref[k] ? 2*k+1 : 2*k;
      o = pref[k] ? 2*k   : 2*k+1;
      g[k] = -1;
      if (mq[p].size() > 0) g[k] = p;
      else if (mq[o].size() > 0) g[k] = o;
    end
    @(posedge clk_2f);
    #1;
    cyc++;
    if (rst) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      for (int k = 0; k < 2; k++) begin
        pref[k] = 1'b0; ev[k] = 1'b0; ed[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (g[k] >= 0) begin
          ed[k]   = mq[g[k]].pop_front();
          ev[k]   = 1'b1;
          pref[k] = (g[k] == 2*k);
        end else begin
          ev[k] = 1'b0;
        end
      end
      for (int n = 0; n < 4; n++) if (pushed[n]) mq[n].push_back(di[n]);
    end
    chk("validout0", {31'b0, vo0}, {31'b0, ev[0]});
    chk("validout1", {31'b0, vo1}, {31'b0, ev[1]});
    chk("dataout0", {24'b0, do0}, {24'b0, ed[0]});
    chk("dataout1", {24'b0, do1}, {24'b0, ed[1]});
    if (vo0 === 1'b1) begin log0.push_back(do0); lc0.push_back(cyc); end
    if (vo1 === 1'b1) log1.push_back(do1);
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 4; n++) begin vi[n] = 1'b0; di[n] = 8'h00; end
  endtask

  initial begin
    int pe, e2, e3, nv0;
    logic [7:0] d2, d3;
    cyc = 0;
    for (int n = 0; n < 4; n++) low_cnt[n] = 0;
    for (int k = 0; k < 2; k++) begin pref[k] = 0; ev[k] = 0; ed[k] = 0; end

    // 1: reset held with all lanes offering 0xFF
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin vi[n] = 1'b1; di[n] = 8'hFF; end
    repeat (3) tick();
    rst = 1'b0;
    idle_inputs();
    log0.delete(); log1.delete();
    repeat (3) tick();
    chk("t1_no_ff_out0", log0.size(), 0);
    chk("t1_no_ff_out1", log1.size(), 0);

    // 2: lanes 0/1 push pairs in the same cycles -> A0,B0,A1,B1
    log0.delete(); lc0.delete();
    vi[0] = 1; di[0] = 8'hA0; vi[1] = 1; di[1] = 8'hB0;
    tick();
    pe = cyc;
    di[0] = 8'hA1; di[1] = 8'hB1;
    tick();
    idle_inputs();
    repeat (5) tick();
    chk("t2_count", log0.size(), 4);
    if (log0.size() == 4) begin
      chk("t2_b0", {24'b0, log0[0]}, 32'hA0);
      chk("t2_b1", {24'b0, log0[1]}, 32'hB0);
      chk("t2_b2", {24'b0, log0[2]}, 32'hA1);
      chk("t2_b3", {24'b0, log0[3]}, 32'hB1);
      chk("t2_first_edge", lc0[0], pe + 1);
      chk("t2_consecutive", lc0[3] - lc0[0], 3);
    end

    // 3: lane 1 alone, back-to-back
    log0.delete(); lc0.delete();
    vi[1] = 1;
    di[1] = 8'h11; tick();
    di[1] = 8'h22; tick();
    di[1] = 8'h33; tick();
    idle_inputs();
    repeat (4) tick();
    chk("t3_count", log0.size(), 3);
    if (log0.size() == 3) begin
      chk("t3_b0", {24'b0, log0[0]}, 32'h11);
      chk("t3_b2", {24'b0, log0[2]}, 32'h33);
      chk("t3_no_gap", lc0[2] - lc0[0], 2);
    end
    chk("t3_hold", {24'b0, do0}, 32'h33);

    // 4: lanes 2/3 stream incrementing bytes, holding data while not ready
    log1.delete();
    for (int n = 0; n < 4; n++) low_cnt[n] = 0;
    d2 = 8'h00; d3 = 8'h80;
    vi[2] = 1; vi[3] = 1;
    repeat (20) begin
      di[2] = d2; di[3] = d3;
      tick();
      if (pushed[2]) d2++;
      if (pushed[3]) d3++;
    end
    idle_inputs();
    repeat (8) tick();
    chk("t4_ready2_dropped", {31'b0, low_cnt[2] > 0}, 1);
    chk("t4_ready3_dropped", {31'b0, low_cnt[3] > 0}, 1);
    for (int i = 1; i < 16 && i < log1.size(); i++)
      chk($sformatf("t4_alt%0d", i), {31'b0, log1[i][7] ^ log1[i-1][7]}, 1);
    e2 = 0; e3 = 0;
    for (int i = 0; i < log1.size(); i++) begin
      if (log1[i][7]) begin chk("t4_lane3_order", {24'b0, log1[i]}, 32'h80 + e3); e3++; end
      else            begin chk("t4_lane2_order", {24'b0, log1[i]}, e2);         e2++; end
    end
    chk("t4_lane2_all", e2, int'(d2));
    chk("t4_lane3_all", e3, int'(d3) - 32'h80);

    // 5: reset one cycle before any output, then fresh pushes
    vi[0] = 1; di[0] = 8'hC0; vi[2] = 1; di[2] = 8'hD0;
    tick();
    rst = 1; di[0] = 8'hC1; di[2] = 8'hD1;
    log0.delete(); log1.delete();
    tick();
    rst = 0;
    idle_inputs();
    repeat (2) tick();
    chk("t5_no_out0", log0.size(), 0);
    chk("t5_no_out1", log1.size(), 0);
    vi[0] = 1; di[0] = 8'h5A; vi[2] = 1; di[2] = 8'h6B;
    tick();
    idle_inputs();
    tick();
    chk("t5_v0", {31'b0, vo0}, 1);
    chk("t5_v1", {31'b0, vo1}, 1);
    chk("t5_d0", {24'b0, do0}, 32'h5A);
    chk("t5_d1", {24'b0, do1}, 32'h6B);
    tick();

    // 6: lane 3 streams with lanes 0/1 idle after a fresh reset
    rst = 1; tick(); rst = 0;
    log1.delete();
    nv0 = 0;
    d3 = 8'h40;
    vi[3] = 1;
    repeat (12) begin
      di[3] = d3;
      tick();
      if (pushed[3]) d3++;
      if (vo0 !== 1'b0 || do0 !== 8'h00) nv0++;
    end
    idle_inputs();
    repeat (3) tick();
    chk("t6_out0_quiet", nv0, 0);
    chk("t6_out1_count", log1.size(), int'(d3) - 32'h40);

    // Random traffic on all lanes with occasional reset
    repeat (400) begin
      for (int n = 0; n < 4; n++) begin
        vi[n] = 1'($urandom_range(0, 1));
        di[n] = 8'($urandom);
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0;
    idle_inputs();
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
